// File: rtl/cmd_stream_dma_pkg.sv
// Shared AXI constants, FSM state type and burst-sizing helper for the command-stream DMA.
package cmd_stream_dma_pkg;

  localparam logic [1:0]  AxiBurstIncr = 2'b01;
  localparam logic [1:0]  AxiRespOkay  = 2'b00;
  localparam logic [3:0]  AxiArCache   = 4'b0011;
  localparam int unsigned Axi4kBytes   = 4096;

  typedef enum logic [1:0] {
    StIdle,
    StAddr,
    StData
  } dma_state_e;

  // Beats in the next burst: capped by what is left, the burst limit and the 4 KiB page end.
  function automatic int unsigned burst_beats(input int unsigned remaining,
                                              input int unsigned page_offset,
                                              input int unsigned size_log2,
                                              input int unsigned max_burst);
    int unsigned beats;
    beats = (Axi4kBytes - page_offset) >> size_log2;
    if (remaining < beats) beats = remaining;
    if (max_burst < beats) beats = max_burst;
    return beats;
  endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry register FIFO between the AXI R channel and the command stream; outputs are
// driven purely from state so valid never depends on the downstream ready.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_last,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
);

  logic [DATA_WIDTH:0] mem_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;
  logic                push;
  logic                pop;

  assign s_ready = (count_q != 2'd2);
  assign m_valid = (count_q != 2'd0);
  assign push    = s_valid && s_ready;
  assign pop     = m_valid && m_ready;

  assign m_data  = mem_q[rd_ptr_q][DATA_WIDTH-1:0];
  // Stale entries may carry last=1; never show it without valid.
  assign m_last  = m_valid && mem_q[rd_ptr_q][DATA_WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {s_last, s_data};
      end
      wr_ptr_q <= wr_ptr_q ^ push;
      rd_ptr_q <= rd_ptr_q ^ pop;
      count_q  <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/cmd_stream_dma.sv
// Reads a linear region over AXI4 one burst at a time and forwards the data as a single
// command stream packet, with tlast marking only the final beat of the whole transfer.
module cmd_stream_dma
  import cmd_stream_dma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 25,
  parameter int unsigned ID_WIDTH   = 8,
  parameter int unsigned LEN_WIDTH  = 20,
  parameter int unsigned MAX_BURST  = 256
) (
  input  logic                  aclk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [LEN_WIDTH-1:0]  start_len,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ID_WIDTH-1:0]   m_axi_arid,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arlock,
  output logic [3:0]            m_axi_arcache,
  output logic [2:0]            m_axi_arprot,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [ID_WIDTH-1:0]   m_axi_rid,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready,
  output logic                  m_cmd_axis_tvalid,
  output logic                  m_cmd_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_cmd_axis_tdata,
  input  logic                  m_cmd_axis_tready
);

  localparam int unsigned BytesPerBeat = DATA_WIDTH / 8;
  localparam int unsigned SizeLog2     = $clog2(BytesPerBeat);

  dma_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  error_q, error_d;
  logic                  done_q, done_d;
  int unsigned           beats;

  logic                  skid_in_valid;
  logic                  skid_in_ready;
  logic                  skid_in_last;
  logic                  r_hs;
  logic                  t_hs;
  logic                  unused_rid;

  assign unused_rid = ^m_axi_rid;

  // addr/remaining only move on the AR handshake, so the AR fields stay stable while waiting.
  always_comb begin
    beats = burst_beats(32'(remaining_q), 32'(addr_q[11:0]), SizeLog2, MAX_BURST);
  end

  assign m_axi_arvalid = (state_q == StAddr);
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = 8'(beats - 32'd1);
  assign m_axi_arsize  = 3'(SizeLog2);
  assign m_axi_arburst = AxiBurstIncr;
  assign m_axi_arid    = '0;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AxiArCache;
  assign m_axi_arprot  = 3'b000;

  assign skid_in_valid = (state_q == StData) && m_axi_rvalid;
  assign m_axi_rready  = (state_q == StData) && skid_in_ready;
  // remaining is already decremented at AR time, so zero here means the final burst.
  assign skid_in_last  = m_axi_rlast && (remaining_q == '0);
  assign r_hs          = m_axi_rvalid && m_axi_rready;
  assign t_hs          = m_cmd_axis_tvalid && m_cmd_axis_tready;

  assign busy  = (state_q != StIdle);
  assign done  = done_q;
  assign error = error_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    error_d     = error_q | (r_hs && (m_axi_rresp != AxiRespOkay));
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (start_len != '0) begin
            addr_d      = start_addr;
            remaining_d = start_len;
            error_d     = 1'b0;
            state_d     = StAddr;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StAddr: begin
        if (m_axi_arready) begin
          addr_d      = addr_q + ADDR_WIDTH'(beats << SizeLog2);
          remaining_d = remaining_q - LEN_WIDTH'(beats);
          state_d     = StData;
        end
      end
      StData: begin
        if (r_hs && m_axi_rlast && (remaining_q != '0)) begin
          state_d = StAddr;
        end else if (t_hs && m_cmd_axis_tlast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      remaining_q <= '0;
      error_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      error_q     <= error_d;
      done_q      <= done_d;
    end
  end

  axis_skid_buffer #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk    (aclk),
    .rst    (rst),
    .s_valid(skid_in_valid),
    .s_ready(skid_in_ready),
    .s_data (m_axi_rdata),
    .s_last (skid_in_last),
    .m_valid(m_cmd_axis_tvalid),
    .m_ready(m_cmd_axis_tready),
    .m_data (m_cmd_axis_tdata),
    .m_last (m_cmd_axis_tlast)
  );

endmodule

// File: tb/tb_cmd_stream_dma.sv
// Directed + randomized bench: AXI slave backed by an address-hashed memory, random stream
// back-pressure, and a transfer-level model of the expected bursts and stream contents.
module tb_cmd_stream_dma;

  localparam int AW = 25;
  localparam int LW = 20;
  localparam int IW = 8;
  localparam int DW = 64;

  logic          aclk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] start_len;
  logic          busy, done, error;
  logic [IW-1:0] arid;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic [1:0]    arburst;
  logic          arlock;
  logic [3:0]    arcache;
  logic [2:0]    arprot;
  logic          arvalid, arready;
  logic [IW-1:0] rid;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast, rvalid, rready;
  logic          tvalid, tlast, tready;
  logic [DW-1:0] tdata;

  always #5 aclk = ~aclk;

  cmd_stream_dma dut (
    .aclk             (aclk),
    .rst              (rst),
    .start            (start),
    .start_addr       (start_addr),
    .start_len        (start_len),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .m_axi_arid       (arid),
    .m_axi_araddr     (araddr),
    .m_axi_arlen      (arlen),
    .m_axi_arsize     (arsize),
    .m_axi_arburst    (arburst),
    .m_axi_arlock     (arlock),
    .m_axi_arcache    (arcache),
    .m_axi_arprot     (arprot),
    .m_axi_arvalid    (arvalid),
    .m_axi_arready    (arready),
    .m_axi_rid        (rid),
    .m_axi_rdata      (rdata),
    .m_axi_rresp      (rresp),
    .m_axi_rlast      (rlast),
    .m_axi_rvalid     (rvalid),
    .m_axi_rready     (rready),
    .m_cmd_axis_tvalid(tvalid),
    .m_cmd_axis_tlast (tlast),
    .m_cmd_axis_tdata (tdata),
    .m_cmd_axis_tready(tready)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_word(input int unsigned a);
    logic [31:0] lo;
    lo = (a * 32'd2654435761) ^ 32'hC3C3_3C3C;
    return {a ^ 32'h5A5A_0F0F, lo};
  endfunction

  typedef struct {
    int unsigned addr;
    int unsigned beats;
  } ar_t;

  ar_t         exp_ar[$];
  int unsigned x_addr, x_len;
  int          tbeat, rbeat, err_beat, done_cnt;
  int          arready_pct = 100, rvalid_pct = 100, tready_pct = 100;

  // Slave / sink / monitor state
  logic        serving, r_hs, t_hs, prev_hold, tlast_hs_prev, prev_tlast;
  logic [63:0] prev_tdata;
  int unsigned cur_addr;
  int          cur_left;
  ar_t         e;

  initial begin
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rid = '0;
    tready = 1'b0;
    serving = 1'b0; cur_left = 0; cur_addr = 0; prev_hold = 1'b0; tlast_hs_prev = 1'b0;
    prev_tdata = '0; prev_tlast = 1'b0; r_hs = 1'b0; t_hs = 1'b0;
    forever begin
      @(negedge aclk);
      r_hs = 1'b0;
      if (rst) begin
        serving = 1'b0; cur_left = 0; prev_hold = 1'b0; tlast_hs_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (tlast_hs_prev) chk("done_after_tlast", done, 1);
        if (done) chk("busy_low_with_done", busy, 0);
        if (prev_hold) begin
          chk("tvalid_hold", tvalid, 1);
          chk("tdata_hold", tdata, prev_tdata);
          chk("tlast_hold", tlast, prev_tlast);
        end
        if (arvalid && arready) begin
          chk("single_outstanding", serving, 0);
          chk("ar_expected", exp_ar.size() != 0, 1);
          if (exp_ar.size() != 0) begin
            e = exp_ar.pop_front();
            chk("araddr", araddr, e.addr);
            chk("arlen", arlen, e.beats - 1);
            chk("arsize", arsize, 3);
            chk("arburst", arburst, 1);
            chk("arid", arid, 0);
            chk("arlock_prot", {arlock, arprot}, 0);
            chk("arcache", arcache, 3);
          end
          serving = 1'b1; cur_addr = araddr; cur_left = int'(arlen) + 1;
        end
        r_hs = rvalid && rready;
        if (r_hs) begin
          cur_addr += 8; cur_left--; rbeat++;
          if (rlast) serving = 1'b0;
        end
        t_hs = tvalid && tready;
        if (t_hs) begin
          chk("beat_in_range", tbeat < int'(x_len), 1);
          chk("tdata", tdata, mem_word(x_addr + 8 * tbeat));
          chk("tlast", tlast, tbeat == int'(x_len) - 1);
          tbeat++;
        end
        tlast_hs_prev = t_hs && tlast;
        prev_hold = tvalid && !tready;
        prev_tdata = tdata; prev_tlast = tlast;
      end
      @(posedge aclk);
      #1;
      if (rst) begin
        arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; tready = 1'b0;
      end else begin
        arready = ($urandom_range(99) < arready_pct);
        if (!(rvalid && !r_hs)) begin
          if (serving && cur_left > 0 && $urandom_range(99) < rvalid_pct) begin
            rvalid = 1'b1;
            rdata  = mem_word(cur_addr);
            rlast  = (cur_left == 1);
            rresp  = (rbeat == err_beat) ? 2'b10 : 2'b00;
          end else begin
            rvalid = 1'b0;
            rlast  = 1'b0;
          end
        end
        tready = ($urandom_range(99) < tready_pct);
      end
    end
  end

  task automatic setup_model(input int unsigned addr, input int unsigned len, input int eb);
    int unsigned a, rem, b, bnd;
    exp_ar.delete();
    a = addr; rem = len;
    while (rem > 0) begin
      bnd = (4096 - (a % 4096)) / 8;
      b = rem;
      if (b > 256) b = 256;
      if (b > bnd) b = bnd;
      exp_ar.push_back('{addr: a, beats: b});
      a += b * 8; rem -= b;
    end
    x_addr = addr; x_len = len; tbeat = 0; rbeat = 0; err_beat = eb; done_cnt = 0;
  endtask

  task automatic pulse_start(input int unsigned addr, input int unsigned len);
    @(posedge aclk); #1;
    start = 1'b1; start_addr = AW'(addr); start_len = LW'(len);
    @(posedge aclk); #1;
    start = 1'b0;
  endtask

  task automatic run_xfer(input int unsigned addr, input int unsigned len, input int eb,
                          input bit poke);
    int cyc;
    setup_model(addr, len, eb);
    pulse_start(addr, len);
    if (len == 0) begin
      chk("zero_done", done, 1);
      chk("zero_busy", busy, 0);
      chk("zero_arvalid", arvalid, 0);
    end else begin
      chk("busy_after_start", busy, 1);
      chk("error_cleared", error, 0);
      chk("arvalid_after_start", arvalid, 1);
    end
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      @(posedge aclk); #1;
      cyc++;
      if (poke && cyc == 20) begin
        start = 1'b1; start_addr = '0; start_len = LW'(5);
      end else begin
        start = 1'b0;
      end
    end
    chk("done_seen", done_cnt > 0, 1);
    repeat (3) @(posedge aclk);
    #1;
    chk("done_once", done_cnt, 1);
    chk("beat_count", tbeat, len);
    chk("ars_left", exp_ar.size(), 0);
    chk("error_flag", error, (eb >= 0 && eb < int'(len)));
    chk("busy_idle", busy, 0);
    chk("done_low", done, 0);
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; start_addr = '0; start_len = '0;
    err_beat = -1; x_addr = 0; x_len = 0; tbeat = 0; rbeat = 0; done_cnt = 0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    @(posedge aclk); #1;
    rst = 1'b0;

    run_xfer(32'h0, 4, -1, 1'b0);
    run_xfer(32'h0, 600, -1, 1'b0);
    run_xfer(32'hFF8, 3, -1, 1'b0);

    arready_pct = 50; rvalid_pct = 60; tready_pct = 50;
    run_xfer($urandom_range(0, 8191) * 8, 1000, -1, 1'b1);

    arready_pct = 100; rvalid_pct = 100; tready_pct = 100;
    run_xfer(32'h2000, 4, 1, 1'b0);
    run_xfer(32'h3000, 4, -1, 1'b0);
    run_xfer(32'h0, 0, -1, 1'b0);

    // Reset in the middle of the first burst, with the error flag already raised.
    tready_pct = 70;
    setup_model(32'h0, 600, 3);
    pulse_start(32'h0, 600);
    cyc = 0;
    while (tbeat < 40 && cyc < 5000) begin
      @(posedge aclk); #1;
      cyc++;
    end
    chk("midburst_reached", tbeat >= 40, 1);
    chk("midburst_error", error, 1);
    @(posedge aclk); #2;
    rst = 1'b1;
    #1;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_error", error, 0);
    chk("mrst_arvalid", arvalid, 0);
    chk("mrst_rready", rready, 0);
    chk("mrst_tvalid", tvalid, 0);
    chk("mrst_tlast", tlast, 0);
    @(posedge aclk); @(posedge aclk); #1;
    rst = 1'b0;
    exp_ar.delete();

    arready_pct = 70; rvalid_pct = 80; tready_pct = 60;
    run_xfer($urandom_range(0, 65535) * 8, $urandom_range(1, 700), $urandom_range(0, 3), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
